// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the helper decodes the datapath needs.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    ADC = 3'd1,
    SUB = 3'd2,
    SBC = 3'd3,
    CP  = 3'd4
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_t;

  // N flag doubles as the subtract-path select; reserved codes fall through as ADD.
  function automatic logic alu_n_flag(alu_op_t op);
    return (op == SUB) || (op == SBC) || (op == CP);
  endfunction

  function automatic logic alu_uses_cin(alu_op_t op);
    return (op == ADC) || (op == SBC);
  endfunction

endpackage

// File: rtl/alu_serial_addsub_if.sv
// Start/done request bus between the sequencer and the digit-serial add/sub unit.
interface alu_serial_addsub_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 4
) ();
  localparam int unsigned NDIG = WIDTH / DIGIT;

  logic             start;
  alu_op_t          op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             c_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_h;
  logic             flag_c;
  logic [NDIG-1:0]  dcarry;

  modport master (
    output start, op, op_a, op_b, c_in,
    input  ready, done, result, flag_z, flag_n, flag_h, flag_c, dcarry
  );

  modport slave (
    input  start, op, op_a, op_b, c_in,
    output ready, done, result, flag_z, flag_n, flag_h, flag_c, dcarry
  );
endinterface

// File: rtl/alu_digit_adder.sv
// One DIGIT-bit slice: a + b + cin, or a + ~b + cin when sub is set.
module alu_digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);
  logic [DIGIT-1:0] b_eff;

  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = (DIGIT+1)'(a) + (DIGIT+1)'(b_eff) + (DIGIT+1)'(cin);
endmodule

// File: rtl/alu_serial_addsub.sv
// Digit-serial add/subtract: one DIGIT slice per cycle, LSB first, with Z/N/H/C and per-digit carries.
module alu_serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_serial_addsub_if.slave bus
);
  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((DIGIT == 0) || (WIDTH % DIGIT != 0) || (NDIG < 1)) begin : g_bad_params
    $error("alu_serial_addsub: WIDTH must be a non-zero multiple of DIGIT");
  end

  alu_state_t       state_q;
  logic [CW-1:0]    dig_cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  alu_op_t          op_r;
  logic             carry_q;
  logic             zacc_q;

  logic             is_sub_c;
  logic [DIGIT-1:0] sum_c;
  logic             cout_c;
  logic             dig_out_c;
  logic             last_c;
  logic             zacc_c;
  logic [DIGIT-1:0] slice_c;
  logic [NDIG-1:0]  dcarry_c;
  logic             start_sub_c;
  logic             start_cin_c;

  alu_digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (carry_q),
    .sub  (is_sub_c),
    .sum  (sum_c),
    .cout (cout_c)
  );

  // Subtract keeps an internal (non-inverted) carry; borrow is its complement.
  always_comb begin
    is_sub_c    = alu_n_flag(op_r);
    dig_out_c   = is_sub_c ? ~cout_c : cout_c;
    last_c      = (dig_cnt == CW'(NDIG - 1));
    zacc_c      = zacc_q & (sum_c == '0);
    slice_c     = (op_r == CP) ? a_sh[DIGIT-1:0] : sum_c;
    dcarry_c    = bus.dcarry;
    dcarry_c[dig_cnt] = dig_out_c;
    start_sub_c = alu_n_flag(bus.op);
    start_cin_c = alu_uses_cin(bus.op) & bus.c_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dig_cnt     <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      op_r        <= ADD;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      bus.ready   <= 1'b1;
      bus.done    <= 1'b0;
      bus.result  <= '0;
      bus.flag_z  <= 1'b0;
      bus.flag_n  <= 1'b0;
      bus.flag_h  <= 1'b0;
      bus.flag_c  <= 1'b0;
      bus.dcarry  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start && bus.ready) begin
            a_sh      <= bus.op_a;
            b_sh      <= bus.op_b;
            op_r      <= bus.op;
            carry_q   <= start_sub_c ? ~start_cin_c : start_cin_c;
            zacc_q    <= 1'b1;
            dig_cnt   <= '0;
            bus.ready <= 1'b0;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          bus.result[int'(dig_cnt)*DIGIT +: DIGIT] <= slice_c;
          bus.dcarry <= dcarry_c;
          carry_q    <= cout_c;
          zacc_q     <= zacc_c;
          a_sh       <= a_sh >> DIGIT;
          b_sh       <= b_sh >> DIGIT;
          dig_cnt    <= dig_cnt + CW'(1);
          if (last_c) begin
            bus.flag_z <= zacc_c;
            bus.flag_n <= is_sub_c;
            bus.flag_h <= dcarry_c[0];
            bus.flag_c <= dcarry_c[NDIG-1];
            bus.done   <= 1'b1;
            bus.ready  <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_addsub.sv
// Directed bench for the digit-serial add/sub unit at 8/4 and 16/4.
module tb_alu_serial_addsub;
  import alu_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  alu_serial_addsub_if #(.WIDTH(8),  .DIGIT(4)) b8 ();
  alu_serial_addsub_if #(.WIDTH(16), .DIGIT(4)) b16 ();

  alu_serial_addsub #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(b8.slave)
  );
  alu_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .bus(b16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {done, ready, result, z, n, h, c, dcarry}
  function automatic logic [15:0] snap8();
    return {b8.done, b8.ready, b8.result, b8.flag_z, b8.flag_n, b8.flag_h, b8.flag_c, b8.dcarry};
  endfunction

  function automatic logic [25:0] snap16();
    return {b16.done, b16.ready, b16.result, b16.flag_z, b16.flag_n, b16.flag_h, b16.flag_c, b16.dcarry};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the inputs to show they were captured.
  task automatic go8(input alu_op_t op, input logic [7:0] a, input logic [7:0] b, input logic ci);
    b8.start = 1'b1; b8.op = op; b8.op_a = a; b8.op_b = b; b8.c_in = ci;
    step(1);
    b8.start = 1'b0; b8.op_a = 8'hA5; b8.op_b = 8'h5A; b8.c_in = ~ci;
  endtask

  task automatic go16(input alu_op_t op, input logic [15:0] a, input logic [15:0] b, input logic ci);
    b16.start = 1'b1; b16.op = op; b16.op_a = a; b16.op_b = b; b16.c_in = ci;
    step(1);
    b16.start = 1'b0; b16.op_a = 16'hA5A5; b16.op_b = 16'h5A5A; b16.c_in = ~ci;
  endtask

  task automatic test_reset();
    logic [15:0] g8;
    logic [25:0] g16;
    reset_n = 1'b0;
    #3;
    g8 = snap8();
    checks++;
    if (g8 !== {1'b0, 1'b1, 8'h00, 4'b0000, 2'b00}) begin
      errors++; $display("FAIL reset8 got %h exp %h", g8, {1'b0, 1'b1, 8'h00, 4'b0000, 2'b00});
    end
    g16 = snap16();
    checks++;
    if (g16 !== {1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL reset16 got %h exp %h", g16, {1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000});
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_add();
    logic [15:0] g;
    go8(ADD, 8'h0F, 8'h01, 1'b0);
    checks++;
    if ({b8.done, b8.ready} !== 2'b00) begin
      errors++; $display("FAIL add_busy got %b exp 00", {b8.done, b8.ready});
    end
    step(1);
    checks++;
    if (b8.done !== 1'b0) begin
      errors++; $display("FAIL add_early_done got %b exp 0", b8.done);
    end
    step(1);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'h10, 4'b0010, 2'b01}) begin
      errors++; $display("FAIL add_0f_01 got %h exp %h", g, {1'b1, 1'b1, 8'h10, 4'b0010, 2'b01});
    end
    step(1);
    g = snap8();
    checks++;
    if (g !== {1'b0, 1'b1, 8'h10, 4'b0010, 2'b01}) begin
      errors++; $display("FAIL add_hold got %h exp %h", g, {1'b0, 1'b1, 8'h10, 4'b0010, 2'b01});
    end
  endtask

  task automatic test_carry_in();
    logic [15:0] g;
    go8(ADC, 8'hFF, 8'hFF, 1'b1);
    step(2);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'hFF, 4'b0011, 2'b11}) begin
      errors++; $display("FAIL adc_ff_ff got %h exp %h", g, {1'b1, 1'b1, 8'hFF, 4'b0011, 2'b11});
    end
    go8(ADD, 8'h00, 8'h00, 1'b1);
    step(2);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'h00, 4'b1000, 2'b00}) begin
      errors++; $display("FAIL add_ignores_cin got %h exp %h", g, {1'b1, 1'b1, 8'h00, 4'b1000, 2'b00});
    end
  endtask

  task automatic test_subtract();
    logic [15:0] g;
    go8(SUB, 8'h10, 8'h01, 1'b1);
    step(2);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'h0F, 4'b0110, 2'b01}) begin
      errors++; $display("FAIL sub_10_01 got %h exp %h", g, {1'b1, 1'b1, 8'h0F, 4'b0110, 2'b01});
    end
    go8(SBC, 8'h00, 8'h00, 1'b1);
    step(2);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'hFF, 4'b0111, 2'b11}) begin
      errors++; $display("FAIL sbc_00_00 got %h exp %h", g, {1'b1, 1'b1, 8'hFF, 4'b0111, 2'b11});
    end
    go8(CP, 8'h42, 8'h42, 1'b1);
    step(2);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'h42, 4'b1100, 2'b00}) begin
      errors++; $display("FAIL cp_42_42 got %h exp %h", g, {1'b1, 1'b1, 8'h42, 4'b1100, 2'b00});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] g;
    go8(ADD, 8'h77, 8'h77, 1'b0);
    step(2);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'hEE, 4'b0000, 2'b00}) begin
      errors++; $display("FAIL b2b_add got %h exp %h", g, {1'b1, 1'b1, 8'hEE, 4'b0000, 2'b00});
    end
    // Next request presented in the done cycle.
    go8(SUB, 8'h77, 8'h77, 1'b0);
    checks++;
    if ({b8.done, b8.ready} !== 2'b00) begin
      errors++; $display("FAIL b2b_accept got %b exp 00", {b8.done, b8.ready});
    end
    // Start during RUN must be dropped.
    b8.start = 1'b1; b8.op = ADD; b8.op_a = 8'h01; b8.op_b = 8'h01; b8.c_in = 1'b0;
    step(1);
    b8.start = 1'b0;
    checks++;
    if (b8.done !== 1'b0) begin
      errors++; $display("FAIL b2b_early_done got %b exp 0", b8.done);
    end
    step(1);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'h00, 4'b1100, 2'b00}) begin
      errors++; $display("FAIL b2b_sub got %h exp %h", g, {1'b1, 1'b1, 8'h00, 4'b1100, 2'b00});
    end
    step(3);
    g = snap8();
    checks++;
    if (g !== {1'b0, 1'b1, 8'h00, 4'b1100, 2'b00}) begin
      errors++; $display("FAIL ignored_start got %h exp %h", g, {1'b0, 1'b1, 8'h00, 4'b1100, 2'b00});
    end
  endtask

  task automatic test_wide();
    logic [25:0] g;
    go16(ADD, 16'hFFFF, 16'h0001, 1'b0);
    step(3);
    checks++;
    if (b16.done !== 1'b0) begin
      errors++; $display("FAIL w16_early_done got %b exp 0", b16.done);
    end
    step(1);
    g = snap16();
    checks++;
    if (g !== {1'b1, 1'b1, 16'h0000, 4'b1011, 4'b1111}) begin
      errors++; $display("FAIL w16_add got %h exp %h", g, {1'b1, 1'b1, 16'h0000, 4'b1011, 4'b1111});
    end
    go16(SUB, 16'h1000, 16'h0001, 1'b0);
    step(4);
    g = snap16();
    checks++;
    if (g !== {1'b1, 1'b1, 16'h0FFF, 4'b0110, 4'b0111}) begin
      errors++; $display("FAIL w16_sub got %h exp %h", g, {1'b1, 1'b1, 16'h0FFF, 4'b0110, 4'b0111});
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] g;
    bit          saw_done;
    go8(ADD, 8'h0F, 8'h01, 1'b0);
    step(1);
    reset_n = 1'b0;
    #1;
    g = snap8();
    checks++;
    if (g !== {1'b0, 1'b1, 8'h00, 4'b0000, 2'b00}) begin
      errors++; $display("FAIL abort_reset got %h exp %h", g, {1'b0, 1'b1, 8'h00, 4'b0000, 2'b00});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      if (b8.done) saw_done = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (b8.done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done got %b exp 0", saw_done);
    end
    go8(ADD, 8'h01, 8'h01, 1'b0);
    step(2);
    g = snap8();
    checks++;
    if (g !== {1'b1, 1'b1, 8'h02, 4'b0000, 2'b00}) begin
      errors++; $display("FAIL post_abort_add got %h exp %h", g, {1'b1, 1'b1, 8'h02, 4'b0000, 2'b00});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    b8.start  = 1'b0; b8.op  = ADD; b8.op_a  = '0; b8.op_b  = '0; b8.c_in  = 1'b0;
    b16.start = 1'b0; b16.op = ADD; b16.op_a = '0; b16.op_b = '0; b16.c_in = 1'b0;
    reset_n = 1'b1;
    #2;
    test_reset();
    test_add();
    test_carry_in();
    test_subtract();
    test_back_to_back();
    test_wide();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
